// File: rtl/butterfly_post_mult.sv
// Radix-2 butterfly back end: combines multiplier products into T = B*W, rounds,
// and forms X = A + T / Y = A - T over a 3-stage stalling pipeline with frame tagging.
`ifndef BF_MULT_BITS
`define BF_MULT_BITS 16
`endif

module butterfly_post_mult #(
  parameter int BF_W     = `BF_MULT_BITS,
  parameter int N_POINTS = 64
) (
  input  logic                     xClk,
  input  logic                     xReset,
  input  logic signed [2*BF_W-1:0] xP_rr,
  input  logic signed [2*BF_W-1:0] xP_ii,
  input  logic signed [2*BF_W-1:0] xP_ri,
  input  logic signed [2*BF_W-1:0] xP_ir,
  input  logic signed [BF_W-1:0]   xA_re,
  input  logic signed [BF_W-1:0]   xA_im,
  input  logic                     xScale,
  input  logic                     xInValid,
  output logic                     xInReady,
  output logic signed [BF_W-1:0]   xX_re,
  output logic signed [BF_W-1:0]   xX_im,
  output logic signed [BF_W-1:0]   xY_re,
  output logic signed [BF_W-1:0]   xY_im,
  output logic                     xOutValid,
  input  logic                     xOutReady,
  output logic                     xOutLast,
  output logic                     xOvf,
  input  logic                     xOvfClr
);
  localparam int PW = 2 * BF_W;
  localparam int TW = 2 * BF_W + 1;
  localparam int XW = TW + 1;
  localparam int CW = $clog2(N_POINTS);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_POINTS - 1);
  localparam logic signed [XW-1:0] SMAX_X = {{(XW-BF_W+1){1'b0}}, {(BF_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN_X = {{(XW-BF_W+1){1'b1}}, {(BF_W-1){1'b0}}};
  localparam logic signed [XW-1:0] RND    = {{(XW-BF_W+1){1'b0}}, 1'b1, {(BF_W-2){1'b0}}};
  localparam logic signed [BF_W+1:0] ONE3 = {{(BF_W+1){1'b0}}, 1'b1};

  // Returns {saturated, value} clamped to the BF_W-bit signed range.
  function automatic logic [BF_W:0] sat_fn(input logic signed [XW-1:0] v);
    logic [BF_W:0] r;
    if (v > SMAX_X)      r = {1'b1, SMAX_X[BF_W-1:0]};
    else if (v < SMIN_X) r = {1'b1, SMIN_X[BF_W-1:0]};
    else                 r = {1'b0, v[BF_W-1:0]};
    return r;
  endfunction

  function automatic logic [BF_W:0] fold(input logic signed [BF_W+1:0] s, input logic scale);
    logic signed [BF_W+1:0] v;
    v = scale ? ((s + ONE3) >>> 1) : s;
    return sat_fn({{(XW-BF_W-2){v[BF_W+1]}}, v});
  endfunction

  // Handshake: a transfer happens when valid and ready are both high on a rising edge;
  // the whole pipeline freezes only when stage 3 holds data the sink is not taking.
  logic stall;

  logic                   v1_q, v2_q, v3_q;
  logic signed [TW-1:0]   tr_q, ti_q, tr_d, ti_d;
  logic signed [BF_W-1:0] a1_re_q, a1_im_q, a2_re_q, a2_im_q;
  logic                   sc1_q, sc2_q;
  logic signed [BF_W-1:0] t2_re_q, t2_im_q, t2_re_d, t2_im_d;
  logic signed [BF_W-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
  logic signed [BF_W-1:0] x_re_d, x_im_d, y_re_d, y_im_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic signed [XW-1:0]   rs_re, rs_im, sh_re, sh_im;
  logic                   sat_tr, sat_ti;
  logic signed [BF_W+1:0] ae_re, ae_im, te_re, te_im;
  logic signed [BF_W+1:0] sx_re, sx_im, sy_re, sy_im;
  logic                   sat_xr, sat_xi, sat_yr, sat_yi;
  logic                   ovf_set;

  assign stall    = v3_q & ~xOutReady;
  assign xInReady = ~stall;

  always_comb begin
    tr_d = $signed({xP_rr[PW-1], xP_rr}) - $signed({xP_ii[PW-1], xP_ii});
    ti_d = $signed({xP_ri[PW-1], xP_ri}) + $signed({xP_ir[PW-1], xP_ir});
  end

  // Round half-up by adding half an LSB of the Q1.15 result before the arithmetic shift.
  always_comb begin
    rs_re = $signed({tr_q[TW-1], tr_q}) + RND;
    rs_im = $signed({ti_q[TW-1], ti_q}) + RND;
    sh_re = rs_re >>> (BF_W - 1);
    sh_im = rs_im >>> (BF_W - 1);
    {sat_tr, t2_re_d} = sat_fn(sh_re);
    {sat_ti, t2_im_d} = sat_fn(sh_im);
  end

  always_comb begin
    ae_re = {{2{a2_re_q[BF_W-1]}}, a2_re_q};
    ae_im = {{2{a2_im_q[BF_W-1]}}, a2_im_q};
    te_re = {{2{t2_re_q[BF_W-1]}}, t2_re_q};
    te_im = {{2{t2_im_q[BF_W-1]}}, t2_im_q};
    sx_re = ae_re + te_re;
    sx_im = ae_im + te_im;
    sy_re = ae_re - te_re;
    sy_im = ae_im - te_im;
    {sat_xr, x_re_d} = fold(sx_re, sc2_q);
    {sat_xi, x_im_d} = fold(sx_im, sc2_q);
    {sat_yr, y_re_d} = fold(sy_re, sc2_q);
    {sat_yi, y_im_d} = fold(sy_im, sc2_q);
  end

  // A saturation only counts when its stage actually moves forward.
  always_comb begin
    ovf_set = ~stall & ((v1_q & (sat_tr | sat_ti)) |
                        (v2_q & (sat_xr | sat_xi | sat_yr | sat_yi)));
    ovf_d = ovf_q;
    if (xOvfClr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v3_q & xOutReady) cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge xClk) begin
    if (xReset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      tr_q    <= '0;
      ti_q    <= '0;
      a1_re_q <= '0;
      a1_im_q <= '0;
      sc1_q   <= 1'b0;
      a2_re_q <= '0;
      a2_im_q <= '0;
      sc2_q   <= 1'b0;
      t2_re_q <= '0;
      t2_im_q <= '0;
      x_re_q  <= '0;
      x_im_q  <= '0;
      y_re_q  <= '0;
      y_im_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (!stall) begin
        v1_q    <= xInValid;
        v2_q    <= v1_q;
        v3_q    <= v2_q;
        tr_q    <= tr_d;
        ti_q    <= ti_d;
        a1_re_q <= xA_re;
        a1_im_q <= xA_im;
        sc1_q   <= xScale;
        a2_re_q <= a1_re_q;
        a2_im_q <= a1_im_q;
        sc2_q   <= sc1_q;
        t2_re_q <= t2_re_d;
        t2_im_q <= t2_im_d;
        x_re_q  <= x_re_d;
        x_im_q  <= x_im_d;
        y_re_q  <= y_re_d;
        y_im_q  <= y_im_d;
      end
    end
  end

  assign xX_re     = x_re_q;
  assign xX_im     = x_im_q;
  assign xY_re     = y_re_q;
  assign xY_im     = y_im_q;
  assign xOutValid = v3_q;
  assign xOutLast  = v3_q & (cnt_q == LAST_CNT);
  assign xOvf      = ovf_q;

endmodule

// File: tb/tb_butterfly_post_mult.sv
// Directed bench for butterfly_post_mult: arithmetic reference model, per-transfer
// scoreboard, stall-stability and frame-tag checks, plus literal anchor values.
module tb_butterfly_post_mult;
  localparam int W = 16;
  localparam int N = 64;

  logic xClk = 1'b0;
  always #5 xClk = ~xClk;

  logic                  xReset = 1'b1;
  logic signed [2*W-1:0] xP_rr = '0, xP_ii = '0, xP_ri = '0, xP_ir = '0;
  logic signed [W-1:0]   xA_re = '0, xA_im = '0;
  logic                  xScale = 1'b0, xInValid = 1'b0, xOutReady = 1'b1, xOvfClr = 1'b0;
  logic                  xInReady, xOutValid, xOutLast, xOvf;
  logic signed [W-1:0]   xX_re, xX_im, xY_re, xY_im;

  butterfly_post_mult #(.BF_W(W), .N_POINTS(N)) dut (
    .xClk(xClk), .xReset(xReset),
    .xP_rr(xP_rr), .xP_ii(xP_ii), .xP_ri(xP_ri), .xP_ir(xP_ir),
    .xA_re(xA_re), .xA_im(xA_im), .xScale(xScale),
    .xInValid(xInValid), .xInReady(xInReady),
    .xX_re(xX_re), .xX_im(xX_im), .xY_re(xY_re), .xY_im(xY_im),
    .xOutValid(xOutValid), .xOutReady(xOutReady), .xOutLast(xOutLast),
    .xOvf(xOvf), .xOvfClr(xOvfClr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the butterfly equations.
  function automatic longint sat_l(input longint v, inout bit f);
    longint mx = (longint'(1) << (W - 1)) - 1;
    longint mn = -(longint'(1) << (W - 1));
    if (v > mx) begin f = 1'b1; return mx; end
    if (v < mn) begin f = 1'b1; return mn; end
    return v;
  endfunction

  function automatic longint out_l(input longint s, input bit sc, inout bit f);
    if (sc) return sat_l((s + 1) >>> 1, f);
    return sat_l(s, f);
  endfunction

  function automatic logic [4*W:0] model(input longint ar, input longint ai, input longint prr,
                                         input longint pii, input longint pri, input longint pir,
                                         input bit sc);
    bit f = 1'b0;
    longint half = longint'(1) << (W - 2);
    longint tr = sat_l(((prr - pii) + half) >>> (W - 1), f);
    longint ti = sat_l(((pri + pir) + half) >>> (W - 1), f);
    longint xr = out_l(ar + tr, sc, f);
    longint xi = out_l(ai + ti, sc, f);
    longint yr = out_l(ar - tr, sc, f);
    longint yi = out_l(ai - ti, sc, f);
    return {W'(xr), W'(xi), W'(yr), W'(yi), f};
  endfunction

  logic [4*W:0]   exp_q[$];
  int             out_cnt = 0;
  int             last_pos[$];
  bit             held_v = 1'b0;
  logic [4*W-1:0] held_d;

  // Single compare process: inputs are driven just after posedge, so the negedge
  // sees the values that the coming posedge will transfer.
  always @(negedge xClk) begin
    logic [4*W:0] e;
    if (xReset) begin
      exp_q.delete();
      last_pos.delete();
      out_cnt = 0;
      held_v  = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", xOutValid, 1);
        chk("hold_data", {xX_re, xX_im, xY_re, xY_im}, held_d);
      end
      if (xInValid && xInReady)
        exp_q.push_back(model(xA_re, xA_im, xP_rr, xP_ii, xP_ri, xP_ir, xScale));
      if (xOutValid && xOutReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("x_re", xX_re, $signed(e[4*W:3*W+1]));
          chk("x_im", xX_im, $signed(e[3*W:2*W+1]));
          chk("y_re", xY_re, $signed(e[2*W:W+1]));
          chk("y_im", xY_im, $signed(e[W:1]));
          if (e[0]) chk("ovf_sticky", xOvf, 1);
        end
        chk("out_last", xOutLast, ((out_cnt % N) == N - 1) ? 1 : 0);
        if (xOutLast) last_pos.push_back(out_cnt + 1);
        out_cnt++;
      end
      held_v = xOutValid && !xOutReady;
      held_d = {xX_re, xX_im, xY_re, xY_im};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge xClk);
    #1;
  endtask

  task automatic send(input longint ar, input longint ai, input longint prr, input longint pii,
                      input longint pri, input longint pir, input bit sc);
    bit got = 1'b0;
    xA_re = W'(ar);  xA_im = W'(ai);
    xP_rr = (2*W)'(prr); xP_ii = (2*W)'(pii); xP_ri = (2*W)'(pri); xP_ir = (2*W)'(pir);
    xScale = sc; xInValid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge xClk);
      if (xInReady) begin got = 1'b1; break; end
    end
    if (!got) chk("send_timeout", 0, 1);
    @(posedge xClk); #1;
    xInValid = 1'b0;
  endtask

  longint bp_v[6][7] = '{
    '{100, -200, 1073741824, -1073741824, 0, 0, 1},
    '{-5, 7, -16384, 0, 0, -16385, 0},
    '{-32768, -32768, 0, 536854528, 536854528, 0, 0},
    '{1234, -4321, 98765432, 1234567, -7654321, 333, 0},
    '{-1, 1, 16383, 0, 16384, 0, 1},
    '{32767, -32768, -536870912, 0, 0, 536870912, 1}
  };

  initial begin : main
    // Reset held for two cycles
    tick(2);
    chk("rst_out_valid", xOutValid, 0);
    chk("rst_x_re", xX_re, 0);
    chk("rst_y_im", xY_im, 0);
    chk("rst_last", xOutLast, 0);
    chk("rst_ovf", xOvf, 0);
    chk("rst_in_ready", xInReady, 1);
    xReset = 1'b0;
    tick(2);

    // Basic butterfly, exact 3-cycle latency
    send(1000, 0, 536854528, 0, 0, 0, 0);
    chk("lat_v_c1", xOutValid, 0);
    tick(1);
    chk("lat_v_c2", xOutValid, 0);
    tick(1);
    chk("basic_valid", xOutValid, 1);
    chk("basic_x_re", xX_re, 17384);
    chk("basic_x_im", xX_im, 0);
    chk("basic_y_re", xY_re, -15384);
    chk("basic_y_im", xY_im, 0);
    chk("basic_ovf", xOvf, 0);
    tick(3);

    // Output saturation, then scaled version of the same operands
    send(32767, 0, 536854528, 0, 0, 0, 0);
    tick(2);
    chk("sat_x_re", xX_re, 32767);
    chk("sat_ovf", xOvf, 1);
    xOvfClr = 1'b1; tick(1); xOvfClr = 1'b0;
    chk("ovf_cleared", xOvf, 0);
    tick(2);
    send(32767, 0, 536854528, 0, 0, 0, 1);
    tick(2);
    chk("scale_x_re", xX_re, 24576);
    chk("scale_y_re", xY_re, 8192);
    chk("scale_ovf", xOvf, 0);
    tick(3);

    // Clear colliding with a stage-3 saturation: set wins
    send(32767, 0, 536854528, 0, 0, 0, 0);
    tick(1);
    xOvfClr = 1'b1; tick(1); xOvfClr = 1'b0;
    chk("clr_vs_set_ovf", xOvf, 1);
    xOvfClr = 1'b1; tick(1); xOvfClr = 1'b0;
    chk("clr_alone_ovf", xOvf, 0);
    tick(3);

    // Backpressure: sink stalls 5 cycles while 6 operands arrive back to back
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(bp_v[i][0], bp_v[i][1], bp_v[i][2], bp_v[i][3], bp_v[i][4], bp_v[i][5], bp_v[i][6] != 0);
      end
      begin
        xOutReady = 1'b0;
        tick(3);
        chk("bp_in_ready_drop", xInReady, 0);
        tick(2);
        xOutReady = 1'b1;
      end
    join
    tick(6);
    xOvfClr = 1'b1; tick(1); xOvfClr = 1'b0;

    // Mid-operation reset discards in-flight data
    send(10, 20, 1000000, 0, 0, 0, 0);
    send(30, 40, 2000000, 0, 0, 0, 0);
    xReset = 1'b1; tick(1);
    chk("midrst_valid", xOutValid, 0);
    chk("midrst_in_ready", xInReady, 1);
    xReset = 1'b0;
    tick(4);
    chk("midrst_no_out", xOutValid, 0);

    // Frame tagging over 130 continuous transfers
    for (int i = 0; i < 130; i++)
      send((i * 97) % 2000 - 1000, 500 - i * 7, i * 1000003, -(i * 777), i * 4096, -(i * 3), i[0]);
    tick(6);
    chk("frame_last_count", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      chk("frame_last_pos0", last_pos[0], 64);
      chk("frame_last_pos1", last_pos[1], 128);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule

// File: doc/butterfly_post_mult.md
BUTTERFLY_POST_MULT -- requirements
Module: butterfly_post_mult

Interface
REQ-001 SHALL have parameter BF_W, default `BF_MULT_BITS (16): data width of A inputs and of the X/Y outputs.
REQ-002 SHALL have parameter N_POINTS, default 64: output transfers per frame, a power of 2 from 2 to 4096.
REQ-003 SHALL have port xClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port xReset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports xP_rr, xP_ii, xP_ri, xP_ir  input  2*BF_W each  signed multiplier products Br*Wr, Bi*Wi, Br*Wi, Bi*Wr, Q2.30 format.
REQ-006 SHALL have ports xA_re, xA_im  input  BF_W each  signed top butterfly operand, Q1.15, time-aligned with the products.
REQ-007 SHALL have port xScale  input  1  1 = divide butterfly outputs by 2; sampled with the data.
REQ-008 SHALL have ports xInValid  input  1 and xInReady  output  1  input handshake.
REQ-009 SHALL have ports xX_re, xX_im, xY_re, xY_im  output  BF_W each  signed results X=A+T, Y=A-T, where T = B*W.
REQ-010 SHALL have ports xOutValid  output  1 and xOutReady  input  1  output handshake.
REQ-011 SHALL have port xOutLast  output  1  qualifies the last output of each N_POINTS frame.
REQ-012 SHALL have ports xOvf  output  1 (sticky saturation flag) and xOvfClr  input  1 (clears xOvf).

Function
REQ-013 An input transfer SHALL occur on a cycle with xInValid=1 and xInReady=1; an output transfer SHALL occur on a cycle with xOutValid=1 and xOutReady=1.
REQ-014 The pipeline SHALL have 3 register stages, each with a valid bit; stall = v3 & ~xOutReady; all stages SHALL hold when stall=1 and advance otherwise.
REQ-015 xInReady SHALL equal ~stall (combinational); bubbles SHALL NOT be collapsed; transfer order SHALL be preserved; no data SHALL be lost or duplicated.
REQ-016 Stage 1 SHALL register Tr = P_rr - P_ii and Ti = P_ri + P_ir at 2*BF_W+1 bits, together with A and xScale.
REQ-017 Stage 2 SHALL round each T by computing (T + 2^(BF_W-2)) >>> (BF_W-1), arithmetic shift, round-half-up, then saturate the result to BF_W bits.
REQ-018 Stage 3 SHALL form X and Y at BF_W+1 bits; if scale=1 it SHALL output (s+1)>>>1, otherwise s saturated to BF_W bits.
REQ-019 Latency SHALL be 3 cycles from input transfer to xOutValid when there is no stall.
REQ-020 Saturation limits SHALL be +(2^(BF_W-1)-1) and -2^(BF_W-1).
REQ-021 xOvf SHALL set on any saturation event (stage 2 or stage 3) in a valid stage that advances.
REQ-022 xOvf SHALL clear when xOvfClr=1; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-023 A frame counter (log2 N_POINTS bits) SHALL increment on each output transfer and SHALL wrap from N_POINTS-1 to 0.
REQ-024 xOutLast SHALL equal xOutValid & (count==N_POINTS-1).
REQ-025 Outputs SHALL remain stable while xOutValid=1 and xOutReady=0.

Reset
REQ-026 While xReset=1: all valid bits=0, xOutValid=0, xX/xY=0, xOutLast=0, xOvf=0, frame count=0, xInReady=1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight data on the next clock edge; the first input transfer after reset SHALL start frame position 0.

Verification
REQ-028 Reset: hold xReset 2 cycles -> all outputs 0, xInReady=1, xOvf=0.
REQ-029 Basic: A=(1000,0), P_rr=536854528 (16384*32767), other products 0, scale=0 -> 3 cycles later X=(17384,0), Y=(-15384,0), xOvf=0.
REQ-030 Saturation: A_re=32767 with the same products: scale=0 -> X_re=32767 and xOvf=1; scale=1 -> X_re=24576, Y_re=8192, no new saturation.
REQ-031 Backpressure: 6 back-to-back inputs with xOutReady=0 for 5 cycles -> xInReady drops once v3=1; all 6 outputs emerge in order, each held stable while stalled.
REQ-032 Frame: 130 continuous transfers with N_POINTS=64 -> xOutLast=1 only on transfers 64 and 128.
REQ-033 xOvfClr and a saturation event in the same cycle -> xOvf remains 1; xOvfClr alone -> xOvf=0 on the next cycle.
